// File: rtl/stats_pkg.sv
// Shared definitions for the statistics front end: sample width, packer FSM
// states and a width helper for sample counters.
package stats_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Smallest w with (1 << w) >= value, usable in constant expressions.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sample_window_packer.sv
// Packs a serial 8-bit sample stream into one SIZE-bit window with valid/ack handoff.
// Optional macro WINDOW_OVERLAP_EN: 50% overlap, the upper half of a released window seeds the next.
module sample_window_packer
    import stats_pkg::*;
#(
    parameter int SIZE          = 512,
    parameter int LOG2_N_VALUES = 6,
    parameter int DEBUG         = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SAMPLE_W-1:0]        sample_in,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic [SIZE-1:0]            window_out,
    output logic                       window_valid,
    input  logic                       window_ack,
    output logic [LOG2_N_VALUES:0]     fill_count
);

    localparam int N_VALUES = SIZE / SAMPLE_W;
    localparam int CNT_W    = LOG2_N_VALUES + 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_VALUES - 1);
`ifdef WINDOW_OVERLAP_EN
    localparam logic [CNT_W-1:0] RESTART_COUNT = CNT_W'(N_VALUES / 2);
`else
    localparam logic [CNT_W-1:0] RESTART_COUNT = '0;
`endif

    if (SIZE != (SAMPLE_W << LOG2_N_VALUES) || clog2(N_VALUES + 1) != CNT_W) begin : g_size_check
        $error("sample_window_packer: SIZE must equal 8 << LOG2_N_VALUES");
    end
    if (DEBUG < 0 || DEBUG > 1) begin : g_debug_check
        $error("sample_window_packer: DEBUG must be 0 or 1");
    end

    state_t             state;
    state_t             state_next;
    logic [SIZE-1:0]    window_next;
    logic [CNT_W-1:0]   count_next;
    logic               accept;

    // Both handshake outputs are pure state decodes, so no path from sample_valid.
    assign sample_ready = (state == FILL);
    assign window_valid = (state == HOLD);
    assign accept       = sample_valid && sample_ready;

    always_comb begin
        state_next  = state;
        count_next  = fill_count;
        window_next = window_out;
        case (state)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < N_VALUES; k++) begin
                        if (fill_count == CNT_W'(k)) begin
                            window_next[k*SAMPLE_W +: SAMPLE_W] = sample_in;
                        end
                    end
                    count_next = fill_count + CNT_W'(1);
                    if (fill_count == LAST_SLOT) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (window_ack) begin
                    state_next = FILL;
                    count_next = RESTART_COUNT;
`ifdef WINDOW_OVERLAP_EN
                    for (int k = 0; k < N_VALUES / 2; k++) begin
                        window_next[k*SAMPLE_W +: SAMPLE_W] =
                            window_out[(k + N_VALUES / 2)*SAMPLE_W +: SAMPLE_W];
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            fill_count <= '0;
            window_out <= '0;
        end else begin
            state      <= state_next;
            fill_count <= count_next;
            window_out <= window_next;
        end
    end

endmodule

// File: tb/tb_sample_window_packer.sv
// Self-checking bench for sample_window_packer: vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_sample_window_packer;

    localparam int S_SIZE = 32;
    localparam int S_LOG  = 2;
    localparam int S_N    = 4;
    localparam int L_SIZE = 512;
    localparam int L_LOG  = 6;
    localparam int L_N    = 64;

`ifdef WINDOW_OVERLAP_EN
    localparam logic [2:0]  R_CNT = 3'd2;
    localparam logic [31:0] W_ACK = 32'h44334433;
    localparam logic [31:0] W_AA  = 32'h44AA4433;
`else
    localparam logic [2:0]  R_CNT = 3'd0;
    localparam logic [31:0] W_ACK = 32'h44332211;
    localparam logic [31:0] W_AA  = 32'h443322AA;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]        s_in;
    logic              s_v, s_rdy, s_wv, s_ack;
    logic [S_SIZE-1:0] s_win;
    logic [S_LOG:0]    s_cnt;

    logic [7:0]        l_in;
    logic              l_v, l_rdy, l_wv, l_ack;
    logic [L_SIZE-1:0] l_win;
    logic [L_LOG:0]    l_cnt;

    sample_window_packer #(.SIZE(S_SIZE), .LOG2_N_VALUES(S_LOG), .DEBUG(0)) dut_small (
        .clk(clk), .rst(rst), .sample_in(s_in), .sample_valid(s_v), .sample_ready(s_rdy),
        .window_out(s_win), .window_valid(s_wv), .window_ack(s_ack), .fill_count(s_cnt)
    );

    sample_window_packer #(.SIZE(L_SIZE), .LOG2_N_VALUES(L_LOG), .DEBUG(0)) dut_large (
        .clk(clk), .rst(rst), .sample_in(l_in), .sample_valid(l_v), .sample_ready(l_rdy),
        .window_out(l_win), .window_valid(l_wv), .window_ack(l_ack), .fill_count(l_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_small(input logic [7:0] value);
        s_v  = 1'b1;
        s_in = value;
        tick();
        s_v  = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  s;
        logic        a;
        logic        e_rdy;
        logic        e_val;
        logic [2:0]  e_cnt;
        logic        cw;
        logic [31:0] e_win;
    } vec_t;

    vec_t tv[12];
    logic [7:0] q[$];
    logic [31:0] exp_win;
    bit hold;
    int sum;
    int bad;

    initial begin
        rst = 1'b1; s_v = 1'b0; s_in = '0; s_ack = 1'b0;
        l_v = 1'b0; l_in = '0; l_ack = 1'b0;
        #1;
        chk("reset_ready", s_rdy, 1'b1);
        chk("reset_valid", s_wv, 1'b0);
        chk("reset_count", s_cnt, 0);
        chk("reset_window", s_win, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic fill, backpressure in HOLD, ack, refill and ack-while-filling.
        tv[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 32'h0};
        tv[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 32'h0};
        tv[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 32'h0};
        tv[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'h44332211};
        for (int i = 4; i < 9; i++) tv[i] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'h44332211};
        tv[9]  = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, R_CNT, 1'b1, W_ACK};
        tv[10] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, R_CNT + 3'd1, 1'b1, W_AA};
        tv[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, R_CNT + 3'd1, 1'b1, W_AA};
        for (int i = 0; i < 12; i++) begin
            s_v = tv[i].v; s_in = tv[i].s; s_ack = tv[i].a;
            tick();
            chk($sformatf("vec%0d_ready", i), s_rdy, tv[i].e_rdy);
            chk($sformatf("vec%0d_valid", i), s_wv, tv[i].e_val);
            chk($sformatf("vec%0d_count", i), s_cnt, tv[i].e_cnt);
            if (tv[i].cw) chk($sformatf("vec%0d_window", i), s_win, tv[i].e_win);
        end
        s_v = 1'b0; s_ack = 1'b0;

        // Mid-fill asynchronous reset discards the partial window.
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        feed_small(8'hDE); feed_small(8'hAD); feed_small(8'hBE);
        chk("midfill_count_before", s_cnt, 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ready", s_rdy, 1'b1);
        chk("async_rst_valid", s_wv, 1'b0);
        chk("async_rst_count", s_cnt, 0);
        chk("async_rst_window", s_win, 0);
        #2 rst = 1'b0;
        feed_small(8'h01); feed_small(8'h02); feed_small(8'h03);
        chk("midfill_not_valid_early", s_wv, 1'b0);
        feed_small(8'h04);
        chk("midfill_valid", s_wv, 1'b1);
        chk("midfill_window", s_win, 32'h04030201);

        // Release and build the next window.
        s_ack = 1'b1; tick(); s_ack = 1'b0;
        chk("ack_count", s_cnt, R_CNT);
        chk("ack_valid", s_wv, 1'b0);
`ifdef WINDOW_OVERLAP_EN
        feed_small(8'h55); feed_small(8'h66);
        exp_win = 32'h66550403;
`else
        feed_small(8'h55); feed_small(8'h66); feed_small(8'h77); feed_small(8'h88);
        exp_win = 32'h88776655;
`endif
        chk("second_valid", s_wv, 1'b1);
        chk("second_window", s_win, exp_win);

        // Randomized traffic against a queue model of the stored samples.
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            s_v   = 1'($urandom_range(0, 1));
            s_in  = 8'($urandom);
            s_ack = ($urandom_range(0, 3) == 0);
            hold  = (q.size() == S_N);
            if (!hold && s_v) begin
                q.push_back(s_in);
            end else if (hold && s_ack) begin
`ifdef WINDOW_OVERLAP_EN
                q = q[S_N/2:$];
`else
                q.delete();
`endif
            end
            tick();
            chk("rnd_ready", s_rdy, q.size() != S_N);
            chk("rnd_valid", s_wv, q.size() == S_N);
            chk("rnd_count", s_cnt, q.size());
            if (q.size() == S_N) begin
                for (int k = 0; k < S_N; k++) exp_win[k*8 +: 8] = q[k];
                chk("rnd_window", s_win, exp_win);
            end
        end
        s_v = 1'b0; s_ack = 1'b0;

        // Gapped input on the full-size window.
        for (int c = 0; c < 128; c++) begin
            l_v  = (c % 2 == 0);
            l_in = 8'(c / 2);
            tick();
            if (c == 124) begin
                chk("gap_valid_at_63", l_wv, 1'b0);
                chk("gap_count_at_63", l_cnt, 63);
            end
            if (c == 126) begin
                chk("gap_valid_at_64", l_wv, 1'b1);
                chk("gap_count_at_64", l_cnt, 64);
            end
        end
        l_v = 1'b0;
        chk("gap_ready_hold", l_rdy, 1'b0);
        sum = 0;
        bad = 0;
        for (int k = 0; k < L_N; k++) begin
            sum += int'(l_win[k*8 +: 8]);
            if (l_win[k*8 +: 8] != 8'(k)) bad++;
        end
        chk("gap_bad_bytes", bad, 0);
        chk("gap_sum", sum, 2016);
        chk("gap_mean", (sum + L_N / 2) / L_N, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
